alien_swarm: RTL

//  Renders and moves a ROWS x COLS formation of 16x16 invader sprites as one VGA layer.
//  Per-alien alive mask; killed by index from the collision logic.

---
 rtl/alien_swarm_if.sv | 30 +++
 rtl/alien_swarm.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alien_swarm_if.sv
// Scan position, kill request and swarm status between the VGA pipeline and the invader layer.
// The VGA/collision side is master; the swarm layer is slave.
interface alien_swarm_if #(
    parameter int IW = 5
);
    logic [11:0]   pixel_row;
    logic [11:0]   pixel_column;
    logic          enable;
    logic          hit_valid;
    logic [IW-1:0] hit_idx;
    logic [3:0]    swarm_output;
    logic          swarm_active;
    logic          hit_ack;
    logic [IW:0]   alive_count;
    logic          frame;
    logic          swarm_landed;
    logic          swarm_cleared;

    modport master (
        output pixel_row, pixel_column, enable, hit_valid, hit_idx,
        input  swarm_output, swarm_active, hit_ack, alive_count, frame,
               swarm_landed, swarm_cleared
    );

    modport slave (
        input  pixel_row, pixel_column, enable, hit_valid, hit_idx,
        output swarm_output, swarm_active, hit_ack, alive_count, frame,
               swarm_landed, swarm_cleared
    );
endinterface

// File: rtl/alien_swarm.sv
// Invader formation layer: zero-latency sprite render, one-cycle kill ack, stepped march FSM.
// No backpressure: a kill is accepted or ignored in the cycle it is presented.
module alien_swarm #(
    parameter int         ROWS       = 3,
    parameter int         COLS       = 8,
    parameter int         PITCH_X    = 24,
    parameter int         PITCH_Y    = 24,
    parameter int         STEP_X     = 12,
    parameter int         STEP_Y     = 24,
    parameter int         TICK       = 16000000,
    parameter int         LEFT_LIM   = 21,
    parameter int         RIGHT_LIM  = 636,
    parameter int         BOTTOM_LIM = 400,
    parameter int         START_ROW  = 20,
    parameter int         START_COL  = 40,
    parameter logic [3:0] COLOR      = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    alien_swarm_if.slave  bus
);
    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [15:0] FRAME0 [16] = '{
        16'h0000, 16'h03C0, 16'h0FF0, 16'h1FF8, 16'h3DBC, 16'h3FFC, 16'h3FFC, 16'h1FF8,
        16'hFFFF, 16'h0E70, 16'h1C38, 16'h3018, 16'h0000, 16'h0000, 16'h0000, 16'h0C30
    };
    localparam logic [15:0] FRAME1 [16] = '{
        16'h0000, 16'h03C0, 16'h0FF0, 16'h1FF8, 16'h3DBC, 16'h3FFC, 16'h3FFC, 16'h1FF8,
        16'hFFFF, 16'h1818, 16'h300C, 16'h6006, 16'h0000, 16'h0000, 16'h0000, 16'h300C
    };

    typedef enum logic [1:0] {MARCH_R, MARCH_L, LANDED, CLEARED} state_t;

    state_t          state_q, state_d;
    logic [11:0]     origin_row, origin_col;
    logic [TW-1:0]   tick_q;
    logic [N-1:0]    alive;
    logic [IW:0]     alive_count;
    logic            frame_q, hit_ack_q, landed_q, cleared_q;

    logic [CW-1:0]   cmin, cmax;
    logic [RW-1:0]   rmax;
    logic [11:0]     right_edge, left_edge, drop_row, drop_bottom;
    logic            marching, tick_done, hit_ok;
    logic            clear_now, step, drop, land;

    // Extent of the living formation, from the registered mask only.
    always_comb begin
        cmin = '0;
        cmax = '0;
        rmax = '0;
        for (int c = COLS - 1; c >= 0; c--)
            for (int r = 0; r < ROWS; r++)
                if (alive[r*COLS + c]) cmin = CW'(c);
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (alive[r*COLS + c]) cmax = CW'(c);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (alive[r*COLS + c]) rmax = RW'(r);
    end

    assign right_edge  = origin_col + 12'(cmax) * 12'(PITCH_X) + 12'(16 + STEP_X);
    assign left_edge   = origin_col + 12'(cmin) * 12'(PITCH_X) + 12'd1;
    assign drop_row    = origin_row + 12'(STEP_Y);
    assign drop_bottom = drop_row + 12'(rmax) * 12'(PITCH_Y) + 12'd16;

    assign marching  = (state_q == MARCH_R) || (state_q == MARCH_L);
    assign tick_done = (tick_q == TW'(TICK - 1));
    assign hit_ok    = bus.hit_valid && ({1'b0, bus.hit_idx} < (IW+1)'(N)) && alive[bus.hit_idx];

    always_ff @(posedge clk) begin
        if (rst) state_q <= MARCH_R;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear_now)
            state_d = CLEARED;
        else if (land)
            state_d = LANDED;
        else if (drop)
            state_d = (state_q == MARCH_R) ? MARCH_L : MARCH_R;
    end

    // Clearing wins over any step that would land in the same cycle.
    always_comb begin
        clear_now = (alive_count == '0) && (state_q != CLEARED);
        step      = 1'b0;
        drop      = 1'b0;
        land      = 1'b0;
        if (!clear_now && marching && bus.enable && tick_done) begin
            step = 1'b1;
            drop = (state_q == MARCH_R) ? (right_edge > 12'(RIGHT_LIM))
                                        : (left_edge < 12'(LEFT_LIM + STEP_X));
            land = drop && (drop_bottom >= 12'(BOTTOM_LIM));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            origin_row  <= 12'(START_ROW);
            origin_col  <= 12'(START_COL);
            tick_q      <= '0;
            alive       <= '1;
            alive_count <= (IW+1)'(N);
            frame_q     <= 1'b0;
            hit_ack_q   <= 1'b0;
            landed_q    <= 1'b0;
            cleared_q   <= 1'b0;
        end else begin
            hit_ack_q <= hit_ok;
            if (hit_ok) begin
                alive[bus.hit_idx] <= 1'b0;
                alive_count        <= alive_count - (IW+1)'(1);
            end
            if (marching && bus.enable)
                tick_q <= tick_done ? '0 : tick_q + TW'(1);
            if (step) begin
                frame_q <= ~frame_q;
                if (drop)
                    origin_row <= drop_row;
                else if (state_q == MARCH_R)
                    origin_col <= origin_col + 12'(STEP_X);
                else
                    origin_col <= origin_col - 12'(STEP_X);
            end
            if (state_d == LANDED)  landed_q  <= 1'b1;
            if (state_d == CLEARED) cleared_q <= 1'b1;
        end
    end

    logic [11:0] base_r, base_c;
    logic [3:0]  ly, lx;
    logic [15:0] bits;
    logic        act, lit;

    // Cells never overlap, so at most one cell claims the current pixel.
    always_comb begin
        act    = 1'b0;
        lit    = 1'b0;
        base_r = '0;
        base_c = '0;
        ly     = '0;
        lx     = '0;
        bits   = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                base_r = origin_row + 12'(r * PITCH_Y);
                base_c = origin_col + 12'(c * PITCH_X);
                if (alive[r*COLS + c] &&
                    bus.pixel_row    > base_r && bus.pixel_row    <= base_r + 12'd16 &&
                    bus.pixel_column > base_c && bus.pixel_column <= base_c + 12'd16) begin
                    act  = 1'b1;
                    ly   = 4'(bus.pixel_row - base_r - 12'd1);
                    lx   = 4'(bus.pixel_column - base_c - 12'd1);
                    bits = frame_q ? FRAME1[ly] : FRAME0[ly];
                    lit  = bits[4'd15 - lx];
                end
            end
        end
    end

    assign bus.swarm_output  = (act && lit) ? COLOR : 4'd0;
    assign bus.swarm_active  = act;
    assign bus.hit_ack       = hit_ack_q;
    assign bus.alive_count   = alive_count;
    assign bus.frame         = frame_q;
    assign bus.swarm_landed  = landed_q;
    assign bus.swarm_cleared = cleared_q;
endmodule
